// File: rtl/bit_serializer_pkg.sv
// Shared types for the bit serializer: FSM state encodings.
package bit_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } ser_state_e;

endpackage

// File: rtl/ser_hold_buf.sv
// One-entry holding buffer in front of the serializer shift register.
module ser_hold_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              consume_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              vld_o,
    output logic              ready_o
);

    logic [DATA_W-1:0] data_q;
    logic              vld_q;

    // A load wins over a consume so a same-edge refill keeps the entry valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            if (load_i)
                data_q <= data_i;
            vld_q <= load_i | (vld_q & ~consume_i);
        end
    end

    assign data_o  = data_q;
    assign vld_o   = vld_q;
    assign ready_o = ~vld_q;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage with a one-word holding buffer for gapless output.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              hold,
    output logic              dout,
    output logic              dout_valid,
    output logic              word_done,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    ser_state_e        state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] buf_data;
    logic              buf_vld;
    logic              load, consume, end_word;
    logic              out_bit;
    logic [DATA_W-1:0] sreg_shift;
`ifdef SERIALIZER_PARITY_EN
    logic              par_q, par_d;
`endif

    assign load = s_valid & s_ready;

    ser_hold_buf #(.DATA_W(DATA_W)) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (load),
        .consume_i(consume),
        .data_i   (s_data),
        .data_o   (buf_data),
        .vld_o    (buf_vld),
        .ready_o  (s_ready)
    );

    assign out_bit    = (MSB_FIRST != 0) ? sreg_q[DATA_W-1] : sreg_q[0];
    assign sreg_shift = (MSB_FIRST != 0) ? {sreg_q[DATA_W-2:0], 1'b0}
                                         : {1'b0, sreg_q[DATA_W-1:1]};

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        cnt_d      = cnt_q;
        consume    = 1'b0;
        end_word   = 1'b0;
        dout       = 1'b0;
        dout_valid = 1'b0;
        word_done  = 1'b0;
`ifdef SERIALIZER_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (buf_vld) begin
                    state_d = SHIFT;
                    sreg_d  = buf_data;
                    cnt_d   = '0;
                    consume = 1'b1;
`ifdef SERIALIZER_PARITY_EN
                    par_d   = ^buf_data;
`endif
                end
            end
            SHIFT: begin
                dout       = out_bit;
                dout_valid = ~hold;
                if (!hold) begin
                    if (cnt_q == LAST) begin
                        cnt_d = '0;
`ifdef SERIALIZER_PARITY_EN
                        state_d = PAR;
`else
                        word_done = 1'b1;
                        end_word  = 1'b1;
`endif
                    end else begin
                        sreg_d = sreg_shift;
                        cnt_d  = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef SERIALIZER_PARITY_EN
            PAR: begin
                dout       = par_q;
                dout_valid = ~hold;
                word_done  = ~hold;
                end_word   = ~hold;
            end
`endif
            default: state_d = IDLE;
        endcase

        // Reload straight from the buffer so back-to-back words leave no gap.
        if (end_word) begin
            if (buf_vld) begin
                state_d = SHIFT;
                sreg_d  = buf_data;
                cnt_d   = '0;
                consume = 1'b1;
`ifdef SERIALIZER_PARITY_EN
                par_d   = ^buf_data;
`endif
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SERIALIZER_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) par_q <= 1'b0;
        else        par_q <= par_d;
    end
`endif

    assign busy = (state_q != IDLE) | buf_vld;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first and an LSB-first instance run in lockstep.
module tb_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       hold;
    logic       s_ready_m, dout_m, dout_valid_m, word_done_m, busy_m;
    logic       s_ready_l, dout_l, dout_valid_l, word_done_l, busy_l;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bit_serializer #(.DATA_W(8), .MSB_FIRST(1)) u_m (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_m), .s_data(s_data),
        .hold(hold), .dout(dout_m), .dout_valid(dout_valid_m), .word_done(word_done_m), .busy(busy_m)
    );

    bit_serializer #(.DATA_W(8), .MSB_FIRST(0)) u_l (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_l), .s_data(s_data),
        .hold(hold), .dout(dout_l), .dout_valid(dout_valid_l), .word_done(word_done_l), .busy(busy_l)
    );

    typedef struct {
        logic [7:0] d;
        logic [7:0] em;   // bit order out of the MSB-first instance, first bit at [7]
        logic [7:0] el;   // bit order out of the LSB-first instance, first bit at [7]
        logic       par;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [8:0] expv(input logic [7:0] s, input logic p);
        return (FL == 9) ? {s, p} : {1'b0, s};
    endfunction

    // Drives up to two words, optional 3-cycle hold after hold_after bits, and
    // returns early (before driving) once stop_at bits have been emitted.
    task automatic run(input logic [7:0] d0, input logic [7:0] d1, input int nw,
                       input int hold_after, input int stop_at,
                       output logic [17:0] gm, output logic [17:0] gl, output int nb,
                       output int wdc, output int wdbad, output int span,
                       output int holdbad, output int rdylow, output bit to);
        int  first, wi, hc;
        bit  vd, rs;
        logic fd;
        gm = '0; gl = '0; nb = 0; wdc = 0; wdbad = 0; span = 0; holdbad = 0; rdylow = 0;
        to = 1'b1; first = -1; wi = 0; hc = 0; vd = 1'b1; rs = 1'b0; fd = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (vd && rs) begin
                wi++;
                vd = (wi < nw);
            end
            if (nb == stop_at) begin
                to = 1'b0;
                break;
            end
            hold    = (hold_after >= 0) && (nb == hold_after) && (hc < 3);
            s_valid = vd;
            s_data  = (wi == 0) ? d0 : d1;
            #1;
            rs = s_ready_m;
            if (vd && !rs && wi > 0) rdylow = 1;
            if (hold) begin
                if (hc == 0) fd = dout_m;
                else if (dout_m !== fd) holdbad++;
                if (dout_valid_m !== 1'b0) holdbad++;
                hc++;
            end
            if (word_done_m && !(dout_valid_m && (nb % FL) == FL - 1)) wdbad++;
            if (dout_valid_m) begin
                gm = {gm[16:0], dout_m};
                gl = {gl[16:0], dout_l};
                if (first < 0) first = c;
                if (word_done_m) wdc++;
                nb++;
                if (nb == nw * FL) begin
                    span = c - first + 1;
                    to   = 1'b0;
                    break;
                end
            end
        end
        s_valid = 1'b0;
        hold    = 1'b0;
    endtask

    initial begin
        logic [17:0] gm, gl;
        int nb, wdc, wdbad, span, holdbad, rdylow, stray;
        bit to;

        tbl[0] = '{8'hB0, 8'hB0, 8'h0D, 1'b1};
        tbl[1] = '{8'h0D, 8'h0D, 8'hB0, 1'b1};
        tbl[2] = '{8'hA5, 8'hA5, 8'hA5, 1'b0};
        tbl[3] = '{8'hC3, 8'hC3, 8'hC3, 1'b0};
        tbl[4] = '{8'h07, 8'h07, 8'hE0, 1'b1};
        tbl[5] = '{8'hFF, 8'hFF, 8'hFF, 1'b0};
        tbl[6] = '{8'h00, 8'h00, 8'h00, 1'b0};

        rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00; hold = 1'b0;
        #1;
        chk("reset_outputs_msb", {s_ready_m, dout_m, dout_valid_m, word_done_m, busy_m}, 5'b10000);
        chk("reset_outputs_lsb", {s_ready_l, dout_l, dout_valid_l, word_done_l, busy_l}, 5'b10000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run(tbl[i].d, 8'h00, 1, -1, -1, gm, gl, nb, wdc, wdbad, span, holdbad, rdylow, to);
            chk($sformatf("word%0d_timeout", i), 32'(to), 0);
            chk($sformatf("word%0d_msb_bits", i), 32'(gm[8:0]), 32'(expv(tbl[i].em, tbl[i].par)));
            chk($sformatf("word%0d_lsb_bits", i), 32'(gl[8:0]), 32'(expv(tbl[i].el, tbl[i].par)));
            chk($sformatf("word%0d_done_count", i), 32'(wdc), 1);
            chk($sformatf("word%0d_done_misplaced", i), 32'(wdbad), 0);
            chk($sformatf("word%0d_span", i), 32'(span), FL);
        end

        // Back-to-back words with s_valid held: no gap, buffer-full backpressure.
        run(8'hFF, 8'h00, 2, -1, -1, gm, gl, nb, wdc, wdbad, span, holdbad, rdylow, to);
        chk("b2b_timeout", 32'(to), 0);
        chk("b2b_bits", 32'(gm), (FL == 9) ? 32'h3FC00 : 32'h0FF00);
        chk("b2b_span", 32'(span), 2 * FL);
        chk("b2b_ready_dropped", 32'(rdylow), 1);
        chk("b2b_done_count", 32'(wdc), 2);
        chk("b2b_done_misplaced", 32'(wdbad), 0);

        // Three-cycle hold after the second bit of A5.
        run(8'hA5, 8'h00, 1, 2, -1, gm, gl, nb, wdc, wdbad, span, holdbad, rdylow, to);
        chk("hold_timeout", 32'(to), 0);
        chk("hold_bits", 32'(gm[8:0]), 32'(expv(8'hA5, 1'b0)));
        chk("hold_span", 32'(span), FL + 3);
        chk("hold_frozen", 32'(holdbad), 0);

        // Reset while bit 5 of C3 is on dout and 5A sits in the buffer.
        run(8'hC3, 8'h5A, 2, -1, 4, gm, gl, nb, wdc, wdbad, span, holdbad, rdylow, to);
        chk("rst_mid_reached", 32'(to), 0);
        chk("rst_mid_prefix", 32'(gm[3:0]), 4'b1100);
        chk("rst_mid_busy_before", 32'(busy_m), 1);
        s_valid = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk("rst_mid_outputs_msb", {s_ready_m, dout_m, dout_valid_m, word_done_m, busy_m}, 5'b10000);
        chk("rst_mid_outputs_lsb", {s_ready_l, dout_l, dout_valid_l, word_done_l, busy_l}, 5'b10000);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (dout_valid_m || dout_valid_l || word_done_m || busy_m || busy_l) stray++;
        end
        chk("rst_mid_no_stale_bits", 32'(stray), 0);
        chk("rst_mid_ready_after", 32'(s_ready_m), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
